// File: rtl/rtc_bus_pkg.sv
// ============================================================================
// rtc_bus_pkg : shared types and constants for the RTC bus arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package rtc_bus_pkg;

  localparam int RTC_DW                 = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int MAX_WR_STREAK_DEFAULT  = 4;

  localparam logic [RTC_DW-1:0] RDATA_ON_TIMEOUT = 8'hFF;
  localparam logic [RTC_DW-1:0] RD_WDATA_FILL    = 8'h00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT     = 2'd2,
    COMPLETE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    ID_INIT = 2'd0,
    ID_WR   = 2'd1,
    ID_RD   = 2'd2
  } req_id_e;

  // Write-streak bookkeeping at a grant: a read grant or an idle read
  // requester resets the streak; a write grant with a read waiting grows it.
  function automatic logic [2:0] streak_next(
    input logic [2:0] cur,
    input logic       wr_grant,
    input logic       rd_grant,
    input logic       rd_pending
  );
    if (rd_grant || !rd_pending) begin
      return 3'd0;
    end
    if (wr_grant && (cur != 3'd7)) begin
      return cur + 3'd1;
    end
    return cur;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_txn_watchdog.sv
// ============================================================================
// rtc_txn_watchdog : WAIT-state cycle counter with clear and expired flag
// Rev 1.0
// ============================================================================
`default_nettype none

module rtc_txn_watchdog
  import rtc_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Expiry fires in the TIMEOUT_CYCLES-th enabled cycle, so the owner sees
  // exactly TIMEOUT_CYCLES WAIT cycles before the abort.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST_COUNT);

endmodule

`default_nettype wire

// File: rtl/rtc_bus_arbiter.sv
// ============================================================================
// rtc_bus_arbiter : per-transaction arbiter sharing the RTC transaction engine
// Rev 1.0
// ============================================================================
`default_nettype none

module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int MAX_WR_STREAK  = MAX_WR_STREAK_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_init,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wdata,
  input  logic       req_wr,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_wdata,
  input  logic       req_rd,
  input  logic [7:0] rd_addr,
  output logic       gnt_init,
  output logic       gnt_wr,
  output logic       gnt_rd,
  output logic       ack_init,
  output logic       ack_wr,
  output logic       ack_rd,
  output logic [7:0] rdata,
  output logic       txn_start,
  output logic [7:0] txn_addr,
  output logic [7:0] txn_wdata,
  output logic       txn_write,
  input  logic       txn_done,
  input  logic [7:0] txn_rdata,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam logic [2:0] STREAK_LIMIT = 3'(MAX_WR_STREAK);

  arb_state_e  state_q,  state_d;
  req_id_e     owner_q,  owner_d;
  logic [2:0]  gnt_q,    gnt_d;      // {init, wr, rd}
  logic [7:0]  addr_q,   addr_d;
  logic [7:0]  wdata_q,  wdata_d;
  logic        write_q,  write_d;
  logic [7:0]  rdata_q,  rdata_d;
  logic [2:0]  streak_q, streak_d;
  logic        terr_q,   terr_d;

  logic wd_expired;
  logic rd_first;
  logic grant_init;
  logic grant_wr;
  logic grant_rd;

  rtc_txn_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != WAIT),
    .enable  (state_q == WAIT),
    .expired (wd_expired)
  );

  // A read that has watched MAX_WR_STREAK writes go by jumps ahead of the
  // write requester; init still outranks everyone.
  assign rd_first   = (streak_q == STREAK_LIMIT) && req_rd && !req_init;
  assign grant_init = req_init;
  assign grant_wr   = !req_init && req_wr && !rd_first;
  assign grant_rd   = !req_init && req_rd && (!req_wr || rd_first);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    streak_d = streak_q;
    terr_d   = err_clr ? 1'b0 : terr_q;

    case (state_q)
      IDLE: begin
        if (grant_init || grant_wr || grant_rd) begin
          state_d  = ISSUE;
          gnt_d    = {grant_init, grant_wr, grant_rd};
          streak_d = streak_next(streak_q, grant_wr, grant_rd, req_rd);
          if (grant_init) begin
            owner_d = ID_INIT;
            addr_d  = init_addr;
            wdata_d = init_wdata;
            write_d = 1'b1;
          end else if (grant_wr) begin
            owner_d = ID_WR;
            addr_d  = wr_addr;
            wdata_d = wr_wdata;
            write_d = 1'b1;
          end else begin
            owner_d = ID_RD;
            addr_d  = rd_addr;
            wdata_d = RD_WDATA_FILL;
            write_d = 1'b0;
          end
        end
      end

      ISSUE: begin
        if (txn_done) begin
          state_d = COMPLETE;
          if (!write_q) begin
            rdata_d = txn_rdata;
          end
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A completion landing in the expiring cycle still counts as success.
        if (txn_done) begin
          state_d = COMPLETE;
          if (!write_q) begin
            rdata_d = txn_rdata;
          end
        end else if (wd_expired) begin
          state_d = COMPLETE;
          terr_d  = 1'b1;
          rdata_d = RDATA_ON_TIMEOUT;
        end
      end

      COMPLETE: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= ID_INIT;
      gnt_q    <= 3'b000;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      write_q  <= 1'b0;
      rdata_q  <= 8'h00;
      streak_q <= 3'd0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
      streak_q <= streak_d;
      terr_q   <= terr_d;
    end
  end

  assign gnt_init    = gnt_q[2];
  assign gnt_wr      = gnt_q[1];
  assign gnt_rd      = gnt_q[0];
  assign ack_init    = (state_q == COMPLETE) && (owner_q == ID_INIT);
  assign ack_wr      = (state_q == COMPLETE) && (owner_q == ID_WR);
  assign ack_rd      = (state_q == COMPLETE) && (owner_q == ID_RD);
  assign rdata       = rdata_q;
  assign txn_start   = (state_q == ISSUE);
  assign txn_addr    = addr_q;
  assign txn_wdata   = wdata_q;
  assign txn_write   = write_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_arbiter.sv
// ============================================================================
// tb_rtc_bus_arbiter : directed and randomized checks of rtc_bus_arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rtc_bus_arbiter;

  localparam int TO   = 20;
  localparam int MAXS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_init, req_wr, req_rd;
  logic [7:0] init_addr, init_wdata, wr_addr, wr_wdata, rd_addr;
  logic       gnt_init, gnt_wr, gnt_rd, ack_init, ack_wr, ack_rd;
  logic [7:0] rdata, txn_addr, txn_wdata, txn_rdata;
  logic       txn_start, txn_write, txn_done, busy, timeout_err, err_clr;
  logic [7:0] ctl;

  rtc_bus_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .MAX_WR_STREAK  (MAXS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_init    (req_init),
    .init_addr   (init_addr),
    .init_wdata  (init_wdata),
    .req_wr      (req_wr),
    .wr_addr     (wr_addr),
    .wr_wdata    (wr_wdata),
    .req_rd      (req_rd),
    .rd_addr     (rd_addr),
    .gnt_init    (gnt_init),
    .gnt_wr      (gnt_wr),
    .gnt_rd      (gnt_rd),
    .ack_init    (ack_init),
    .ack_wr      (ack_wr),
    .ack_rd      (ack_rd),
    .rdata       (rdata),
    .txn_start   (txn_start),
    .txn_addr    (txn_addr),
    .txn_wdata   (txn_wdata),
    .txn_write   (txn_write),
    .txn_done    (txn_done),
    .txn_rdata   (txn_rdata),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  assign ctl = {txn_start, busy, gnt_init, gnt_wr, gnt_rd, ack_init, ack_wr, ack_rd};

  int n_chk   = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int m_streak = 0;   // model: consecutive write grants with a read waiting
  bit m_terr   = 1'b0;
  bit perturb  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (failure #%0d)", tag, obs, exp, n_fail);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference priority: init first, then write unless a read has waited
  // through MAXS write grants, then read. 0=init 1=wr 2=rd.
  function automatic int pick_winner();
    if (req_init) return 0;
    if (req_wr && !(req_rd && (m_streak == MAXS))) return 1;
    if (req_rd) return 2;
    return -1;
  endfunction

  // One transaction from the IDLE cycle where requests are already set.
  // lat >= 0: engine pulses txn_done lat cycles after ISSUE; lat < 0: never.
  task automatic txn(input int lat, input int exp_id, input logic [7:0] eng_rdata);
    int         id;
    logic [7:0] ea, ew, exp_rd;
    logic       ewr;
    logic [2:0] eg;
    id = (exp_id >= 0) ? exp_id : pick_winner();
    case (id)
      0:       begin ea = init_addr; ew = init_wdata; end
      1:       begin ea = wr_addr;   ew = wr_wdata;   end
      default: begin ea = rd_addr;   ew = 8'h00;      end
    endcase
    ewr = (id != 2);
    eg  = 3'b100 >> id;
    if ((id == 2) || !req_rd) m_streak = 0;
    else if ((id == 1) && (m_streak < 7)) m_streak++;
    exp_rd = 8'h00;

    tick();
    chk("issue_ctl",  {24'd0, ctl}, {24'd0, 1'b1, 1'b1, eg, 3'b000});
    chk("issue_txn",  {15'd0, txn_addr, txn_wdata, txn_write}, {15'd0, ea, ew, ewr});
    if (perturb) begin
      init_addr = 8'($urandom); init_wdata = 8'($urandom);
      wr_addr   = 8'($urandom); wr_wdata   = 8'($urandom);
      rd_addr   = 8'($urandom);
    end
    if (lat >= 0) begin
      for (int i = 0; i < lat; i++) begin
        tick();
        chk("wait_ctl", {24'd0, ctl}, {24'd0, 1'b0, 1'b1, eg, 3'b000});
      end
      txn_done  = 1'b1;
      txn_rdata = eng_rdata;
      tick();
      txn_done  = 1'b0;
      txn_rdata = 8'($urandom);
      exp_rd    = eng_rdata;
    end else begin
      for (int i = 0; i < TO; i++) begin
        tick();
        chk("wait_ctl", {24'd0, ctl}, {24'd0, 1'b0, 1'b1, eg, 3'b000});
      end
      tick();
      exp_rd = 8'hFF;
      m_terr = 1'b1;
    end
    chk("complete_ctl", {24'd0, ctl}, {24'd0, 1'b0, 1'b1, eg, eg});
    chk("complete_txn", {15'd0, txn_addr, txn_wdata, txn_write}, {15'd0, ea, ew, ewr});
    if (id == 2) chk("rdata", {24'd0, rdata}, {24'd0, exp_rd});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
    case (id)
      0:       req_init = 1'b0;
      1:       req_wr   = 1'b0;
      default: req_rd   = 1'b0;
    endcase
    tick();
    chk("idle_ctl", {24'd0, ctl}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_init = 1'b0; req_wr = 1'b0; req_rd = 1'b0;
    init_addr = 8'h00; init_wdata = 8'h00; wr_addr = 8'h00; wr_wdata = 8'h00;
    rd_addr = 8'h00; txn_done = 1'b0; txn_rdata = 8'h00; err_clr = 1'b0;

    // Reset state
    tick(); tick();
    chk("reset_ctl", {24'd0, ctl}, 32'd0);
    chk("reset_data", {7'd0, txn_addr, txn_wdata, rdata, txn_write},
                      {7'd0, 8'h00, 8'h00, 8'h00, 1'b0});
    chk("reset_terr", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_reset_idle", {24'd0, ctl}, 32'd0);

    // Single read, engine answers after 10 cycles
    req_rd = 1'b1; rd_addr = 8'h21;
    txn(10, 2, 8'h59);

    // Three-way collision: init, then wr, then rd
    req_init = 1'b1; init_addr = 8'h02; init_wdata = 8'h10;
    req_wr   = 1'b1; wr_addr   = 8'h22; wr_wdata   = 8'h30;
    req_rd   = 1'b1; rd_addr   = 8'h31;
    txn(3, 0, 8'h00);
    txn(2, 1, 8'h00);
    txn(5, 2, 8'hA5);

    // Starvation guard: four writes, a read, then writes resume
    req_rd = 1'b1; rd_addr = 8'h44;
    for (int k = 0; k < MAXS; k++) begin
      req_wr = 1'b1; wr_addr = 8'(8'h50 + k); wr_wdata = 8'(8'h60 + k);
      txn(1, 1, 8'h00);
    end
    req_wr = 1'b1; wr_addr = 8'h70; wr_wdata = 8'h71;
    txn(1, 2, 8'h3C);
    req_rd = 1'b1; rd_addr = 8'h45;
    txn(1, 1, 8'h00);
    txn(0, 2, 8'hC3);

    // Timeout on a read, stray completion, then error clear
    req_rd = 1'b1; rd_addr = 8'h0E;
    txn(-1, 2, 8'h00);
    txn_done = 1'b1; txn_rdata = 8'h12;
    tick();
    txn_done = 1'b0;
    chk("stray_done_idle", {24'd0, ctl}, 32'd0);
    tick();
    chk("stray_done_still_idle", {24'd0, ctl}, 32'd0);
    chk("terr_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_terr  = 1'b0;
    chk("terr_cleared", {31'd0, timeout_err}, 32'd0);

    // Zero-wait engine
    req_init = 1'b1; init_addr = 8'h0F; init_wdata = 8'h80;
    txn(0, 0, 8'h00);

    // Reset during a write's WAIT
    req_wr = 1'b1; wr_addr = 8'h2B; wr_wdata = 8'h9A;
    tick(); tick(); tick();
    chk("pre_reset_wait", {24'd0, ctl}, {24'd0, 8'b01_010_000});
    #2 reset = 1'b1;
    #1;
    chk("async_reset_ctl", {24'd0, ctl}, 32'd0);
    chk("async_reset_addr", {24'd0, txn_addr}, 32'd0);
    req_wr = 1'b0;
    tick();
    reset = 1'b0;
    m_streak = 0;
    m_terr   = 1'b0;
    tick();
    chk("after_reset_idle", {24'd0, ctl}, 32'd0);
    req_init = 1'b1; init_addr = 8'h03; init_wdata = 8'h55;
    txn(3, 0, 8'h00);

    // Randomized mix against the reference model
    perturb = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (!req_init && ($urandom_range(0, 3) == 0)) begin
        req_init = 1'b1; init_addr = 8'($urandom); init_wdata = 8'($urandom);
      end
      if (!req_wr && ($urandom_range(0, 1) == 0)) begin
        req_wr = 1'b1; wr_addr = 8'($urandom); wr_wdata = 8'($urandom);
      end
      if (!req_rd && ($urandom_range(0, 1) == 0)) begin
        req_rd = 1'b1; rd_addr = 8'($urandom);
      end
      if (!req_init && !req_wr && !req_rd) begin
        req_rd = 1'b1; rd_addr = 8'($urandom);
      end
      txn(int'($urandom_range(0, 10)), -1, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Shares the single RTC transaction engine (the block that drives ChipSelect/Read/Write/AoD on the multiplexed DATA_ADDRESS bus) between three requesters:

- initialization/reset sequencer;
- user-edit write machine;
- background read/poll machine.

It replaces static mode-switch muxing with per-transaction arbitration. Ownership only changes at transaction boundaries, so a reset or mode change never truncates an RTC cycle. It also supervises each transaction with a timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: WAIT-state cycles before a transaction is aborted (1..255).
- MAX_WR_STREAK, 4: consecutive write grants allowed while a read is pending.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_init  in  1  init requester, always a write; held until ack_init
- init_addr / init_wdata  in  8 / 8  init register address / data
- req_wr  in  1  edit-write request; held until ack_wr
- wr_addr / wr_wdata  in  8 / 8  edit-write address / data
- req_rd  in  1  read request; held until ack_rd
- rd_addr  in  8  read address
- gnt_init, gnt_wr, gnt_rd  out  1 each  one-hot ownership level, ISSUE through COMPLETE
- ack_init, ack_wr, ack_rd  out  1 each  one-cycle completion pulse
- rdata  out  8  read result, valid while ack_rd=1
- txn_start  out  1  one-cycle start pulse to engine
- txn_addr / txn_wdata  out  8 / 8  latched address / data, stable ISSUE through COMPLETE
- txn_write  out  1  1=write, 0=read
- txn_done  in  1  engine completion pulse
- txn_rdata  in  8  engine read data, valid with txn_done
- busy  out  1  state ≠ IDLE
- timeout_err  out  1  sticky; set on timeout, cleared by err_clr
- err_clr  in  1  synchronous clear of timeout_err

## Operation
States:
- IDLE: arbitrate.
- ISSUE: txn_start=1.
- WAIT: await txn_done.
- COMPLETE: assert ack, drop gnt.

Arbitration in IDLE, sampled at each edge:
- Priority is init > wr > rd.
- Exception: if wr_streak == MAX_WR_STREAK and req_rd=1 and req_init=0, rd wins over wr.

Grant edge:
- Latch requester id, address, wdata (rd: txn_wdata=0x00) and txn_write.
- Set one-hot gnt.
- Go to ISSUE.

wr_streak (3-bit, saturating):
- Increments on a wr grant while req_rd=1.
- Clears on an rd grant or when req_rd=0 at a grant.

Transaction flow:
- ISSUE lasts exactly one cycle, then WAIT.
- txn_done sampled in ISSUE or WAIT → COMPLETE. For reads, rdata<=txn_rdata.
- WAIT counter (8-bit) starts at 0 on entry. If it reaches TIMEOUT_CYCLES with no txn_done → COMPLETE, timeout_err<=1, rdata<=0xFF.
- COMPLETE lasts one cycle: ack pulse for the owner, gnt deasserted at its end, then IDLE.

Other rules:
- txn_done in IDLE or COMPLETE is ignored.
- Requester changes to req/addr outside IDLE are ignored; latched values are used.
- err_clr and a simultaneous timeout: set wins.
- Reset values: state IDLE; all gnt, ack, txn_start, txn_write, busy, timeout_err = 0; txn_addr, txn_wdata, rdata = 0x00; wr_streak = 0.

## Timing
- Request seen at edge N (IDLE) → gnt, busy, txn_start high in cycle N+1. txn_start falls at N+2.
- txn_done sampled at edge M → ack (and rdata) high for the cycle after M.
- Minimum req→ack: 3 cycles when txn_done arrives during ISSUE.
- Requesters drop req on the edge ending their ack cycle, so the following IDLE arbitrates cleanly. Holding req with new addr/data is a legal back-to-back request.
- Back-to-back throughput: one transaction per (engine latency + 3) cycles.
- reset asserted mid-transaction: all outputs reach reset values immediately and asynchronously. The engine is expected to be reset by the same signal.

## Structure
- Package rtc_bus_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, COMPLETE;
  - requester id codes: ID_INIT, ID_WR, ID_RD;
  - RTC_DW=8;
  - default TIMEOUT_CYCLES.
- One sub-module: rtc_txn_watchdog, the WAIT-state counter with start/clear and an expired flag.
- Everything else is flat in rtc_bus_arbiter.

## Test plan
- Single read: req_rd=1, rd_addr=0x21, engine returns 0x59 after 10 cycles.
  → txn_start one cycle with txn_write=0, txn_addr=0x21; ack_rd pulse with rdata=0x59.
- Collision: req_init (0x02/0x10), req_wr (0x22/0x30) and req_rd raised the same cycle.
  → Order is init, wr, rd; gnt stays one-hot throughout.
- Starvation guard: req_wr held continuously with req_rd=1, MAX_WR_STREAK=4.
  → Exactly 4 write grants, then a read grant, then writes resume.
- Timeout: TIMEOUT_CYCLES=20, engine never pulses txn_done on a read.
  → ack_rd after 20 WAIT cycles, rdata=0xFF, timeout_err=1. Later stray txn_done ignored. err_clr clears timeout_err.
- Reset mid-WAIT: assert reset during a write's WAIT.
  → Immediate gnt_wr=0, busy=0. After release, a new req_init is granted normally.
- Zero-wait engine: txn_done during ISSUE.
  → ack in cycle 3 after request; no lost or duplicate ack.
